// File: rtl/thor2022_pic_if.sv
// Thor2022 PIC 64-bit I/O-bus interface.
// Same handshake as the interval timer block.
interface thor2022_pic_if;
   logic        cs_i;
   logic        cyc_i;
   logic        stb_i;
   logic        ack_o;
   logic [7:0]  sel_i;
   logic        we_i;
   logic [10:0] adr_i;
   logic [63:0] dat_i;
   logic [63:0] dat_o;

   modport master (
      output cs_i, cyc_i, stb_i, sel_i, we_i, adr_i, dat_i,
      input  ack_o, dat_o
   );

   modport slave (
      input  cs_i, cyc_i, stb_i, sel_i, we_i, adr_i, dat_i,
      output ack_o, dat_o
   );
endinterface

// File: rtl/thor2022_pic.sv
// Thor2022 priority interrupt controller.
// Masks and prioritises NSRC sources, presents one request to the core.
module thor2022_pic #(
   parameter int NSRC = 32
) (
   input  logic            rst_i,
   input  logic            clk_i,
   thor2022_pic_if.slave   bus,
   input  logic [NSRC-1:0] src_i,
   input  logic            iack_i,
   output logic            irq_o,
   output logic [2:0]      level_o,
   output logic [7:0]      cause_o
);

   typedef enum logic {S_IDLE, S_ASSERT} state_t;

   state_t          state_q, state_d;
   logic            cs, wr, rdy;
   logic [7:0]      radr;
   logic [63:0]     rd_val;
   logic [NSRC-1:0] pending, enable, mode, src_q;
   logic [NSRC-1:0] elig, clr, pend_d;
   logic [2:0]      imask;
   logic [2:0]      lvl [NSRC];
   logic [2:0]      win_lvl;
   logic [7:0]      win_id;
   logic            any, cur_elig, take;
   logic            irq_d;
   logic [2:0]      level_d;
   logic [7:0]      cause_d;
   logic            unused_bits;

   assign cs          = bus.cs_i & bus.cyc_i & bus.stb_i;
   assign wr          = cs & bus.we_i;
   assign radr        = bus.adr_i[10:3];
   assign bus.ack_o   = cs & (bus.we_i | rdy);
   assign take        = (state_q == S_ASSERT) & iack_i;
   assign unused_bits = ^{bus.sel_i, bus.adr_i[2:0], bus.dat_i};

   always_comb begin
      rd_val = '0;
      case (radr)
         8'h00: rd_val[NSRC-1:0] = pending;
         8'h01: rd_val[NSRC-1:0] = enable;
         8'h02: rd_val[NSRC-1:0] = mode;
         8'h03: rd_val[2:0]      = imask;
         8'h04: rd_val[15:0]     = {irq_o, 4'd0, level_o, cause_o};
         8'h05: rd_val[NSRC-1:0] = src_i;
         default: begin
            for (int n = 0; n < NSRC; n++)
               if (radr == 8'(16 + n))
                  rd_val[2:0] = lvl[n];
         end
      endcase
   end

   // Ascending scan with strict '>' keeps the lowest index on a tie.
   always_comb begin
      elig     = '0;
      win_lvl  = '0;
      win_id   = '0;
      cur_elig = 1'b0;
      for (int n = 0; n < NSRC; n++) begin
         elig[n] = pending[n] & enable[n] & (lvl[n] > imask);
         if (elig[n] && (lvl[n] > win_lvl)) begin
            win_lvl = lvl[n];
            win_id  = 8'(n);
         end
         if (cause_o == 8'(n))
            cur_elig = elig[n];
      end
      any = |elig;
   end

   // A new edge always wins over a W1C or iack clear.
   always_comb begin
      clr    = '0;
      pend_d = '0;
      for (int n = 0; n < NSRC; n++) begin
         clr[n] = (wr && (radr == 8'h00) && bus.dat_i[n])
                | (take && (cause_o == 8'(n)));
         if (mode[n])
            pend_d[n] = (src_i[n] & ~src_q[n])
                      | (pending[n] & ~clr[n]);
         else
            pend_d[n] = src_i[n];
      end
   end

   always_comb begin
      state_d = state_q;
      irq_d   = irq_o;
      level_d = level_o;
      cause_d = cause_o;
      case (state_q)
         S_IDLE: begin
            if (any) begin
               cause_d = win_id;
               level_d = win_lvl;
               irq_d   = 1'b1;
               state_d = S_ASSERT;
            end
         end
         S_ASSERT: begin
            if (iack_i || !cur_elig) begin
               irq_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         irq_o   <= 1'b0;
         level_o <= '0;
         cause_o <= '0;
      end else begin
         state_q <= state_d;
         irq_o   <= irq_d;
         level_o <= level_d;
         cause_o <= cause_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdy       <= 1'b0;
         bus.dat_o <= '0;
      end else begin
         rdy       <= cs;
         bus.dat_o <= cs ? rd_val : '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending <= '0;
         src_q   <= '0;
         enable  <= '0;
         mode    <= '0;
         imask   <= '0;
         for (int n = 0; n < NSRC; n++)
            lvl[n] <= '0;
      end else begin
         pending <= pend_d;
         src_q   <= src_i;
         if (wr) begin
            case (radr)
               8'h01:   enable <= bus.dat_i[NSRC-1:0];
               8'h02:   mode   <= bus.dat_i[NSRC-1:0];
               8'h03:   imask  <= bus.dat_i[2:0];
               default: ;
            endcase
         end
         for (int n = 0; n < NSRC; n++)
            if (wr && (radr == 8'(16 + n)))
               lvl[n] <= bus.dat_i[2:0];
      end
   end

endmodule
